betting_round_ctrl: RTL and testbench

BETTING_ROUND_CTRL -- requirements
Module: betting_round_ctrl

---
 rtl/betting_round_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_betting_round_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/betting_round_ctrl.sv
// Four-player betting round controller: tracks stacks, per-round contributions,
// folds and the pot, and sequences turns until the round closes or one player remains.
//
// state   | meaning
// IDLE    | between rounds; accepts award_valid and round_start
// BETTING | players act in turn; busy is high
// CLOSE   | one-cycle wrap-up carrying the round_done or hand_over pulse
module betting_round_ctrl #(
  parameter logic [7:0] START_STACK = 8'd100,
  parameter logic [7:0] RAISE_AMT   = 8'd10
) (
  input  logic       clk,
  input  logic       reset_d,
  input  logic       round_start,
  input  logic       act_valid,
  input  logic [1:0] act_code,
  input  logic       award_valid,
  input  logic [1:0] award_player,
  output logic [1:0] cur_player,
  output logic [7:0] cur_stack,
  output logic [7:0] to_call,
  output logic [9:0] pot,
  output logic [3:0] active_mask,
  output logic       busy,
  output logic       round_done,
  output logic       hand_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BETTING = 2'd1,
    S_CLOSE   = 2'd2
  } state_t;

  localparam logic [1:0] ACT_CALL  = 2'b00;
  localparam logic [1:0] ACT_RAISE = 2'b01;
  localparam logic [1:0] ACT_FOLD  = 2'b10;
  localparam logic [1:0] ACT_RSV   = 2'b11;
  localparam logic [9:0] TOTAL_CHIPS = {START_STACK, 2'b00};

  state_t     state_q, state_d;
  logic [7:0] stack_q   [4];
  logic [7:0] stack_d   [4];
  logic [7:0] contrib_q [4];
  logic [7:0] contrib_d [4];
  logic [3:0] acted_q, acted_d;
  logic [3:0] active_q, active_d;
  logic [7:0] bet_q, bet_d;
  logic [9:0] pot_q, pot_d;
  logic [1:0] cur_q, cur_d;
  logic [1:0] winner_q, winner_d;
  logic       round_done_q, round_done_d;
  logic       hand_over_q, hand_over_d;
  logic       restore_q, restore_d;

  logic [7:0] tc;
  logic [7:0] need;
  logic [7:0] pay;
  logic [3:0] elig;
  logic [1:0] pick;
  logic       all_ok;
  logic [9:0] chip_sum;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_set = 2'(i);
    end
  endfunction

  // Closest eligible seat after 'from'; stays on 'from' if nobody else qualifies.
  function automatic logic [1:0] next_after(input logic [1:0] from, input logic [3:0] m);
    logic [1:0] idx;
    next_after = from;
    for (int k = 3; k >= 1; k--) begin
      idx = from + 2'(k);
      if (m[idx]) next_after = idx;
    end
  endfunction

  always_ff @(posedge clk or posedge reset_d) begin
    if (reset_d) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < 4; i++) begin
        stack_q[i]   <= START_STACK;
        contrib_q[i] <= '0;
      end
      acted_q      <= '0;
      active_q     <= 4'hF;
      bet_q        <= '0;
      pot_q        <= '0;
      cur_q        <= '0;
      winner_q     <= '0;
      round_done_q <= 1'b0;
      hand_over_q  <= 1'b0;
      restore_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      for (int i = 0; i < 4; i++) begin
        stack_q[i]   <= stack_d[i];
        contrib_q[i] <= contrib_d[i];
      end
      acted_q      <= acted_d;
      active_q     <= active_d;
      bet_q        <= bet_d;
      pot_q        <= pot_d;
      cur_q        <= cur_d;
      winner_q     <= winner_d;
      round_done_q <= round_done_d;
      hand_over_q  <= hand_over_d;
      restore_q    <= restore_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stack_d      = stack_q;
    contrib_d    = contrib_q;
    acted_d      = acted_q;
    active_d     = active_q;
    bet_d        = bet_q;
    pot_d        = pot_q;
    cur_d        = cur_q;
    winner_d     = winner_q;
    restore_d    = restore_q;
    round_done_d = 1'b0;
    hand_over_d  = 1'b0;
    tc           = '0;
    need         = '0;
    pay          = '0;
    elig         = '0;
    pick         = '0;
    all_ok       = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        // The award lands first so a same-cycle round_start sees the paid-out stacks.
        if (award_valid) begin
          stack_d[award_player] = stack_q[award_player] + pot_q[7:0];
          pot_d     = '0;
          active_d  = 4'hF;
          restore_d = 1'b0;
        end
        if (round_start) begin
          for (int i = 0; i < 4; i++) contrib_d[i] = '0;
          acted_d = '0;
          bet_d   = '0;
          if (restore_q) active_d = 4'hF;
          restore_d = 1'b0;
          for (int i = 0; i < 4; i++) elig[i] = active_d[i] && (stack_d[i] != 8'd0);
          if (elig == 4'd0) begin
            state_d      = S_CLOSE;
            round_done_d = 1'b1;
          end else begin
            state_d = S_BETTING;
            cur_d   = lowest_set(elig);
          end
        end
      end

      S_BETTING: begin
        if (act_valid && act_code != ACT_RSV) begin
          tc   = bet_q - contrib_q[cur_q];
          need = bet_q + RAISE_AMT - contrib_q[cur_q];
          pay  = (stack_q[cur_q] < tc) ? stack_q[cur_q] : tc;
          // An unaffordable raise degrades to a call.
          if (act_code == ACT_RAISE && stack_q[cur_q] >= need) begin
            pay     = need;
            bet_d   = bet_q + RAISE_AMT;
            acted_d = '0;
          end
          if (act_code == ACT_FOLD) begin
            pay             = '0;
            active_d[cur_q] = 1'b0;
          end
          acted_d[cur_q]   = 1'b1;
          stack_d[cur_q]   = stack_q[cur_q] - pay;
          contrib_d[cur_q] = contrib_q[cur_q] + pay;
          pot_d            = pot_q + {2'b00, pay};

          // All-in players count as acted and matched.
          for (int i = 0; i < 4; i++) begin
            elig[i] = active_d[i] && (stack_d[i] != 8'd0);
            if (elig[i] && (!acted_d[i] || contrib_d[i] != bet_d)) all_ok = 1'b0;
          end

          if (act_code == ACT_FOLD && $countones(active_d) == 1) begin
            pick          = lowest_set(active_d);
            stack_d[pick] = stack_d[pick] + pot_d[7:0];
            pot_d         = '0;
            winner_d      = pick;
            hand_over_d   = 1'b1;
            restore_d     = 1'b1;
            state_d       = S_CLOSE;
          end else if (all_ok) begin
            round_done_d = 1'b1;
            state_d      = S_CLOSE;
          end else begin
            cur_d = next_after(cur_q, elig);
          end
        end
      end

      S_CLOSE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign cur_player  = cur_q;
  assign cur_stack   = stack_q[cur_q];
  assign to_call     = bet_q - contrib_q[cur_q];
  assign pot         = pot_q;
  assign active_mask = active_q;
  assign busy        = (state_q == S_BETTING);
  assign round_done  = round_done_q;
  assign hand_over   = hand_over_q;
  assign winner      = winner_q;

  always_comb begin
    chip_sum = pot_q;
    for (int i = 0; i < 4; i++) chip_sum = chip_sum + {2'b00, stack_q[i]};
  end

  chip_conservation: assert property (@(posedge clk) disable iff (reset_d) chip_sum == TOTAL_CHIPS);

endmodule

// File: tb/tb_betting_round_ctrl.sv
// Directed bench: a vector table on the default-parameter instance plus a
// hand-written all-in sequence on a small-stack instance.
module tb_betting_round_ctrl;

  localparam bit [1:0] C = 2'b00, R = 2'b01, F = 2'b10, X = 2'b11;

  logic clk = 1'b0;
  logic reset_d = 1'b1;
  always #5 clk = ~clk;

  // Default instance (START 100, RAISE 10).
  logic       rs = 0, av = 0, aw = 0;
  logic [1:0] code = 0, ap = 0;
  logic [1:0] cur, win;
  logic [7:0] stk, tcall;
  logic [9:0] pot;
  logic [3:0] mask;
  logic       busy, rd, ho;

  betting_round_ctrl dut (
    .clk(clk), .reset_d(reset_d), .round_start(rs), .act_valid(av), .act_code(code),
    .award_valid(aw), .award_player(ap), .cur_player(cur), .cur_stack(stk),
    .to_call(tcall), .pot(pot), .active_mask(mask), .busy(busy),
    .round_done(rd), .hand_over(ho), .winner(win));

  // Small-stack instance (START 25, RAISE 10) so odd all-in amounts can arise.
  logic       rs_s = 0, av_s = 0, aw_s = 0;
  logic [1:0] code_s = 0, ap_s = 0;
  logic [1:0] cur_s, win_s;
  logic [7:0] stk_s, tcall_s;
  logic [9:0] pot_s;
  logic [3:0] mask_s;
  logic       busy_s, rd_s, ho_s;

  betting_round_ctrl #(.START_STACK(8'd25), .RAISE_AMT(8'd10)) dut_s (
    .clk(clk), .reset_d(reset_d), .round_start(rs_s), .act_valid(av_s), .act_code(code_s),
    .award_valid(aw_s), .award_player(ap_s), .cur_player(cur_s), .cur_stack(stk_s),
    .to_call(tcall_s), .pot(pot_s), .active_mask(mask_s), .busy(busy_s),
    .round_done(rd_s), .hand_over(ho_s), .winner(win_s));

  typedef struct {
    bit       rst, rs, av;
    bit [1:0] code;
    bit       aw;
    bit [1:0] ap;
    int       cur, stack, tc, pot, mask, busy, rd, ho, win;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input bit rst_i, input bit rs_i, input bit av_i, input bit [1:0] code_i,
                     input bit aw_i, input bit [1:0] ap_i, input int e_cur, input int e_stack,
                     input int e_tc, input int e_pot, input int e_mask, input int e_busy,
                     input int e_rd, input int e_ho, input int e_win);
    vec_t v;
    v.rst = rst_i; v.rs = rs_i; v.av = av_i; v.code = code_i; v.aw = aw_i; v.ap = ap_i;
    v.cur = e_cur; v.stack = e_stack; v.tc = e_tc; v.pot = e_pot; v.mask = e_mask;
    v.busy = e_busy; v.rd = e_rd; v.ho = e_ho; v.win = e_win;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    string t;
    reset_d = v.rst; rs = v.rs; av = v.av; code = v.code; aw = v.aw; ap = v.ap;
    @(posedge clk);
    #1;
    reset_d = 1'b0; rs = 0; av = 0; aw = 0; code = 0; ap = 0;
    n_vec++;
    t = $sformatf("v%0d", idx);
    chk({t, ".cur"},   int'(cur),   v.cur);
    chk({t, ".stack"}, int'(stk),   v.stack);
    chk({t, ".tc"},    int'(tcall), v.tc);
    chk({t, ".pot"},   int'(pot),   v.pot);
    chk({t, ".mask"},  int'(mask),  v.mask);
    chk({t, ".busy"},  int'(busy),  v.busy);
    chk({t, ".rd"},    int'(rd),    v.rd);
    chk({t, ".ho"},    int'(ho),    v.ho);
    if (v.ho != 0) chk({t, ".win"}, int'(win), v.win);
  endtask

  task automatic step_s(input string t, input bit rs_i, input bit av_i, input bit [1:0] code_i,
                        input bit aw_i, input bit [1:0] ap_i, input int e_cur, input int e_stack,
                        input int e_tc, input int e_pot, input int e_mask, input int e_busy,
                        input int e_rd);
    rs_s = rs_i; av_s = av_i; code_s = code_i; aw_s = aw_i; ap_s = ap_i;
    @(posedge clk);
    #1;
    rs_s = 0; av_s = 0; code_s = 0; aw_s = 0; ap_s = 0;
    n_vec++;
    chk({t, ".cur"},   int'(cur_s),   e_cur);
    chk({t, ".stack"}, int'(stk_s),   e_stack);
    chk({t, ".tc"},    int'(tcall_s), e_tc);
    chk({t, ".pot"},   int'(pot_s),   e_pot);
    chk({t, ".mask"},  int'(mask_s),  e_mask);
    chk({t, ".busy"},  int'(busy_s),  e_busy);
    chk({t, ".rd"},    int'(rd_s),    e_rd);
    chk({t, ".ho"},    int'(ho_s),    0);
  endtask

  initial begin
    // rst rs av code aw ap | cur stack tc pot mask busy rd ho win
    // Four checks close the round.
    add(0,1,0,C,0,0, 0,100, 0, 0,'hF,1,0,0,0);
    add(0,0,1,C,0,0, 1,100, 0, 0,'hF,1,0,0,0);
    add(0,0,1,C,0,0, 2,100, 0, 0,'hF,1,0,0,0);
    add(0,0,1,C,0,0, 3,100, 0, 0,'hF,1,0,0,0);
    add(0,0,1,C,0,0, 3,100, 0, 0,'hF,0,1,0,0);
    add(0,0,0,C,0,0, 3,100, 0, 0,'hF,0,0,0,0);
    add(0,0,1,R,0,0, 3,100, 0, 0,'hF,0,0,0,0);   // act in IDLE ignored
    // Raise then three calls.
    add(0,1,0,C,0,0, 0,100, 0, 0,'hF,1,0,0,0);
    add(0,0,1,R,0,0, 1,100,10,10,'hF,1,0,0,0);
    add(0,0,1,C,0,0, 2,100,10,20,'hF,1,0,0,0);
    add(0,0,1,C,0,0, 3,100,10,30,'hF,1,0,0,0);
    add(0,0,1,C,0,0, 3, 90, 0,40,'hF,0,1,0,0);
    add(0,0,0,C,0,0, 3, 90, 0,40,'hF,0,0,0,0);
    add(0,0,0,C,1,0, 3, 90, 0, 0,'hF,0,0,0,0);   // award pot 40 to P0
    // Re-raise forces P0 to act again.
    add(0,1,0,C,0,0, 0,130, 0, 0,'hF,1,0,0,0);
    add(0,0,1,R,0,0, 1, 90,10,10,'hF,1,0,0,0);
    add(0,1,0,C,0,0, 1, 90,10,10,'hF,1,0,0,0);   // round_start in BETTING ignored
    add(0,0,1,R,0,0, 2, 90,20,30,'hF,1,0,0,0);
    add(0,0,1,C,0,0, 3, 90,20,50,'hF,1,0,0,0);
    add(0,0,0,C,1,1, 3, 90,20,50,'hF,1,0,0,0);   // award in BETTING ignored
    add(0,0,1,C,0,0, 0,120,10,70,'hF,1,0,0,0);
    add(0,0,1,X,0,0, 0,120,10,70,'hF,1,0,0,0);   // reserved code ignored
    add(0,0,1,C,0,0, 0,110, 0,80,'hF,0,1,0,0);
    add(0,0,0,C,0,0, 0,110, 0,80,'hF,0,0,0,0);
    // Folds down to one player.
    add(1,0,0,C,0,0, 0,100, 0, 0,'hF,0,0,0,0);
    add(0,1,0,C,0,0, 0,100, 0, 0,'hF,1,0,0,0);
    add(0,0,1,F,0,0, 1,100, 0, 0,'hE,1,0,0,0);
    add(0,0,1,F,0,0, 2,100, 0, 0,'hC,1,0,0,0);
    add(0,0,1,R,0,0, 3,100,10,10,'hC,1,0,0,0);
    add(0,0,1,F,0,0, 3,100,10, 0,'h4,0,0,1,2);
    add(0,0,0,C,0,0, 3,100,10, 0,'h4,0,0,0,0);
    add(0,1,0,C,0,0, 0,100, 0, 0,'hF,1,0,0,0);   // mask restored
    add(0,0,1,C,0,0, 1,100, 0, 0,'hF,1,0,0,0);
    add(0,0,1,C,0,0, 2,100, 0, 0,'hF,1,0,0,0);   // P2 got the pot back
    add(0,0,1,R,0,0, 3,100,10,10,'hF,1,0,0,0);
    add(0,0,1,R,0,0, 0,100,20,30,'hF,1,0,0,0);
    add(1,0,0,C,0,0, 0,100, 0, 0,'hF,0,0,0,0);   // reset mid-round
    add(0,0,1,C,0,0, 0,100, 0, 0,'hF,0,0,0,0);

    repeat (2) @(posedge clk);
    #1;
    reset_d = 1'b0;
    n_vec++;
    chk("rst.cur",   int'(cur),   0);
    chk("rst.stack", int'(stk),   100);
    chk("rst.pot",   int'(pot),   0);
    chk("rst.mask",  int'(mask),  'hF);
    chk("rst.busy",  int'(busy),  0);
    chk("rst.flags", int'({rd, ho, win}), 0);
    chk("rst_s.stack", int'(stk_s), 25);

    foreach (vecs[i]) apply(vecs[i], i);

    // Small stacks: build P0/P1 = 5, award P0, then P1 goes all-in and is skipped.
    step_s("s1",  1,0,C,0,0, 0,25, 0, 0,'hF,1,0);
    step_s("s2",  0,1,R,0,0, 1,25,10,10,'hF,1,0);
    step_s("s3",  0,1,R,0,0, 2,25,20,30,'hF,1,0);
    step_s("s4",  0,1,F,0,0, 3,25,20,30,'hB,1,0);
    step_s("s5",  0,1,F,0,0, 0,15,10,30,'h3,1,0);
    step_s("s6",  0,1,C,0,0, 0, 5, 0,40,'h3,0,1);
    step_s("s6b", 0,0,C,0,0, 0, 5, 0,40,'h3,0,0);
    step_s("s7",  0,0,C,1,0, 0,45, 0, 0,'hF,0,0);
    step_s("s8",  1,0,C,0,0, 0,45, 0, 0,'hF,1,0);
    step_s("s9",  0,1,R,0,0, 1, 5,10,10,'hF,1,0);
    step_s("s10", 0,1,C,0,0, 2,25,10,15,'hF,1,0);
    step_s("s11", 0,1,R,0,0, 3,25,20,35,'hF,1,0);
    step_s("s12", 0,1,C,0,0, 0,35,10,55,'hF,1,0);
    step_s("s13", 0,1,R,0,0, 2, 5,10,75,'hF,1,0);
    step_s("s14", 0,1,C,0,0, 3, 5,10,80,'hF,1,0);
    step_s("s15", 0,1,C,0,0, 3, 0, 5,85,'hF,0,1);
    step_s("s16", 0,0,C,0,0, 3, 0, 5,85,'hF,0,0);
    // Award and round_start together: the round opens on the paid-out stacks.
    step_s("s17", 1,0,C,1,1, 0,15, 0, 0,'hF,1,0);
    step_s("s18", 0,1,C,0,0, 1,85, 0, 0,'hF,1,0);
    step_s("s19", 0,1,C,0,0, 1,85, 0, 0,'hF,0,1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
